// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module   : pc_seq_pkg
// Brief    : Shared constants and state codes for the PC sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pc_seq_pkg;

  localparam int         c_PC_W      = 10;
  localparam logic [9:0] c_RESET_VEC = 10'h000;
  localparam logic [9:0] c_IRQ_VEC   = 10'h3F0;
  localparam int         c_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } pc_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
// Module   : pc_ras
// Brief    : Circular return-address stack; a push when full overwrites the
//            oldest entry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_ras #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_push,
  input  logic [PC_W-1:0] i_push_data,
  input  logic            i_pop,
  output logic            o_empty,
  output logic [PC_W-1:0] o_top
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]    r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_ptr;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_PTR_W-1:0] w_ptr_inc;
  logic [c_PTR_W-1:0] w_ptr_dec;

  // r_ptr is the next write slot; when full it also holds the oldest entry
  assign w_ptr_inc = (r_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
  assign w_ptr_dec = (r_ptr == '0) ? c_PTR_W'(DEPTH - 1) : r_ptr - 1'b1;
  assign o_empty   = (r_cnt == '0);
  assign o_top     = r_mem[w_ptr_dec];

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_ptr <= w_ptr_inc;
      if (r_cnt != c_CNT_W'(DEPTH)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (i_pop && !o_empty) begin
      r_ptr <= w_ptr_dec;
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Next-PC selection and instruction-fetch handshake controller.
//            Optional return-address stack enabled by PC_SEQ_RAS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W      = c_PC_W,
  parameter logic [PC_W-1:0] RESET_VEC = c_RESET_VEC,
  parameter logic [PC_W-1:0] IRQ_VEC   = c_IRQ_VEC,
  parameter int              RAS_DEPTH = c_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_cur,
  output logic [PC_W-1:0] pc_next,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            instr_valid,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  input  logic            call,
  input  logic [PC_W-1:0] link_addr,
  input  logic            ret_valid,
  input  logic [PC_W-1:0] ret_target,
  input  logic            iret,
  input  logic            irq,
  output logic            irq_ack,
  input  logic            halt,
  output logic            halted,
  output logic [2:0]      state
);

  pc_state_e       r_state;
  pc_state_e       w_state_nxt;
  logic            r_busy;
  logic [PC_W-1:0] r_addr;
  logic [PC_W-1:0] r_epc;
  logic            r_insvc;

  logic            w_redir_ok;
  logic            w_br;
  logic            w_iret;
  logic            w_ret;
  logic            w_redir;
  logic [PC_W-1:0] w_ret_pc;
  logic [PC_W-1:0] w_redir_pc;

  assign w_redir_ok = (r_state == ST_IDLE) || (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign w_br       = w_redir_ok && br_valid;
  assign w_iret     = w_redir_ok && !br_valid && iret;
  assign w_ret      = w_redir_ok && !br_valid && !iret && ret_valid;
  assign w_redir    = w_br || w_iret || w_ret;

`ifdef PC_SEQ_RAS_EN
  logic            w_ras_empty;
  logic [PC_W-1:0] w_ras_top;

  pc_ras #(
    .PC_W  (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_br && call),
    .i_push_data (link_addr),
    .i_pop       (w_ret),
    .o_empty     (w_ras_empty),
    .o_top       (w_ras_top)
  );

  assign w_ret_pc = w_ras_empty ? ret_target : w_ras_top;
`else
  logic w_unused_ras;
  assign w_unused_ras = call ^ (^link_addr) ^ (RAS_DEPTH > 0);
  assign w_ret_pc     = ret_target;
`endif

  assign w_redir_pc = w_br ? br_target : (w_iret ? r_epc : w_ret_pc);

  assign imem_req  = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  // First request cycle forwards pc_cur; afterwards the latched copy is held
  assign imem_addr = (imem_req && !r_busy) ? pc_cur : r_addr;
  assign halted    = (r_state == ST_HALT);
  assign state     = r_state;

  always_comb begin
    w_state_nxt = r_state;
    pc_next     = pc_cur;
    instr_valid = 1'b0;
    irq_ack     = 1'b0;
    case (r_state)
      ST_RST: begin
        pc_next     = RESET_VEC;
        w_state_nxt = stall ? ST_IDLE : ST_FETCH;
      end
      ST_IDLE: begin
        if (!stall && !w_redir) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          w_state_nxt = stall ? ST_IDLE : ST_FETCH;
          if (!w_redir) begin
            if (irq && !r_insvc) begin
              pc_next = IRQ_VEC;
              irq_ack = 1'b1;
            end else if (halt) begin
              instr_valid = 1'b1;
              w_state_nxt = ST_HALT;
            end else begin
              instr_valid = 1'b1;
              pc_next     = pc_cur + 1'b1;
            end
          end
        end else if (w_redir) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (imem_ack) w_state_nxt = stall ? ST_IDLE : ST_FETCH;
      end
      default: ;
    endcase
    if (w_redir) pc_next = w_redir_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RST;
      r_busy  <= 1'b0;
      r_addr  <= '0;
      r_epc   <= '0;
      r_insvc <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (imem_req && !r_busy) begin
        r_addr <= pc_cur;
        r_busy <= 1'b1;
      end
      if (imem_req && imem_ack) r_busy <= 1'b0;
      if (irq_ack) begin
        r_epc   <= pc_cur;
        r_insvc <= 1'b1;
      end else if (w_iret) begin
        r_insvc <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller for the 10-bit program counter register. It computes the value loaded into the PC each cycle and runs the instruction-memory request/acknowledge handshake. It merges execute-stage redirects (branch, return, interrupt return), interrupt entry and halt into one next-PC decision. It sits between the PC register (drives its `pc_in`, reads its `pc_out`), instruction memory and the execute stage.

## Interface
- `PC_W`, 10: PC width.
- `RESET_VEC`, 10'h000: first fetch address after reset.
- `IRQ_VEC`, 10'h3F0: interrupt entry address.
- `RAS_DEPTH`, 4: return-address-stack entries (used only with the macro).

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `pc_cur`  in  PC_W  current PC (PC register output).
- `pc_next`  out  PC_W  next PC (to PC register input).
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  PC_W  fetch address.
- `imem_ack`  in  1  single-cycle fetch-done pulse.
- `instr_valid`  out  1  fetched word is on-path.
- `stall`  in  1  decode cannot accept a new fetch.
- `br_valid`  in  1  taken branch or jump.
- `br_target`  in  PC_W  branch target.
- `call`  in  1  qualifies `br_valid` as a call.
- `link_addr`  in  PC_W  return address of the call.
- `ret_valid`  in  1  return.
- `ret_target`  in  PC_W  return address from the register file.
- `iret`  in  1  interrupt return.
- `irq`  in  1  level interrupt request.
- `irq_ack`  out  1  one-cycle pulse on interrupt entry.
- `halt`  in  1  stop fetching.
- `halted`  out  1  halt state flag.
- `state`  out  3  debug state code.

## Operation
- States:
  - RST: one cycle after reset; `pc_next` = RESET_VEC. Goes to IDLE if `stall`, else FETCH.
  - IDLE: `imem_req` = 0. Goes to FETCH when `stall` = 0.
  - FETCH: `imem_req` = 1, held until ack.
  - DRAIN: `imem_req` = 1; waits for a stale ack.
  - HALT: `imem_req` = 0; left only by `reset`.
- `imem_addr` is latched from `pc_cur` when a request starts. It is held constant until `imem_ack`. `imem_req` never drops before ack.
- Default: `pc_next` = `pc_cur` (hold).
- Redirect (any state except RST and HALT). Priority is `br_valid` > `iret` > `ret_valid`; lower-priority requests in the same cycle are ignored.
  - `br_valid`: `pc_next` = `br_target`.
  - `iret`: `pc_next` = saved EPC; clears the in-service flag.
  - `ret_valid`: `pc_next` = `ret_target`.
- Redirect in FETCH without ack: go to DRAIN. In DRAIN, the ack gives `instr_valid` = 0, then FETCH (or IDLE if `stall`).
- Redirect in FETCH with ack in the same cycle: `instr_valid` = 0, then FETCH. Redirect in IDLE or DRAIN: state unchanged.
- FETCH with ack and no redirect, first matching case applies:
  - `irq` and not in-service: `instr_valid` = 0, EPC <= `pc_cur`, `pc_next` = IRQ_VEC, `irq_ack` = 1, in-service set.
  - else `halt`: `instr_valid` = 1, go to HALT, PC held.
  - else `instr_valid` = 1 and `pc_next` = `pc_cur`+1, modulo 2^PC_W (3FF -> 000).
- After an accepted ack, next state is IDLE if `stall`, else FETCH.
- Reset mid-handshake abandons the request; any later ack is ignored until FETCH is re-entered.

## Timing
- Reset values: `imem_req` 0, `imem_addr` 0, `instr_valid` 0, `irq_ack` 0, `halted` 0, `pc_next` RESET_VEC, `state` RST, EPC 0, in-service 0, RAS empty.
- `pc_next` is combinational; the PC register updates one cycle later.
- Best-case throughput is one instruction per 2 cycles (ack, then new request).
- `instr_valid` and `irq_ack` are asserted in the ack cycle only.

## Configuration
- `PC_SEQ_RAS_EN` defined:
  - `br_valid` & `call` pushes `link_addr`. When full, the oldest entry is overwritten.
  - `ret_valid` pops the top entry and uses it as target, ignoring `ret_target`.
  - A pop of an empty stack uses `ret_target`.
- Undefined: no stack; `call` is ignored; `ret_valid` always uses `ret_target`.

## Structure
- Package `pc_seq_pkg`: state enum and its codes, PC_W, RESET_VEC and IRQ_VEC defaults.
- Sub-module `pc_ras`: circular stack with push, pop, empty and top. Instantiated only under `PC_SEQ_RAS_EN`.

## Test plan
- Reset, ack 2 cycles after each request -> `imem_addr` 000, 001, 002, `instr_valid` 1 on each ack.
- `pc_cur` = 3FF, ack -> `pc_next` 000.
- `br_valid` target 0x120 while FETCH waits -> DRAIN, stale ack with `instr_valid` 0, next `imem_addr` 0x120.
- `irq` at ack with `pc_cur` 0x045 -> `irq_ack` 1, `pc_next` 0x3F0; later `iret` -> `pc_next` 0x045; second `irq` before `iret` is ignored.
- With `PC_SEQ_RAS_EN`: 5 calls with links 0x10..0x14, then 5 returns -> targets 0x14, 0x13, 0x12, 0x11, then `ret_target`.
- `halt` at ack -> `halted` 1, `imem_req` 0 indefinitely; `reset` -> RST, `pc_next` RESET_VEC.
